// File: rtl/residual_seq.sv
// residual_seq: per-macroblock residual block sequencer feeding residual_ctrl.
//   Walks the 4:2:0 residual block order for one macroblock. Each block gets one
//   residual_start, then the sequencer waits for residual_valid before moving on,
//   and a done pulse follows the last block.
//   clk, rst          clock, synchronous active-high reset
//   ena               global stall; no state changes and no start/done pulses while low
//   mb_start          begin a macroblock (accepted only when idle)
//   is_intra16x16     macroblock type, latched at mb_start
//   cbp_luma          coded 8x8 luma blocks, latched at mb_start
//   cbp_chroma        chroma coded pattern (0..2, 3 acts as 2), latched at mb_start
//   residual_state    current block type to residual_ctrl
//   residual_start    one-cycle block start to residual_ctrl
//   residual_valid    block finished, from residual_ctrl
//   blk_idx           luma 4x4 index, or chroma AC index within Cb/Cr
//   busy, done        macroblock in progress / one-cycle completion pulse
module residual_seq #(
   parameter bit CHROMA_EN = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ena,
   input  logic       mb_start,
   input  logic       is_intra16x16,
   input  logic [3:0] cbp_luma,
   input  logic [1:0] cbp_chroma,
   output logic [3:0] residual_state,
   output logic       residual_start,
   input  logic       residual_valid,
   output logic [3:0] blk_idx,
   output logic       busy,
   output logic       done
);
   localparam logic [3:0] S_IDLE     = 4'd0;
   localparam logic [3:0] S_I16DC    = 4'd1;
   localparam logic [3:0] S_I16AC    = 4'd2;
   localparam logic [3:0] S_I16AC_0  = 4'd3;
   localparam logic [3:0] S_LUMA     = 4'd4;
   localparam logic [3:0] S_LUMA_0   = 4'd5;
   localparam logic [3:0] S_CDC_CB   = 4'd6;
   localparam logic [3:0] S_CDC_CR   = 4'd7;
   localparam logic [3:0] S_CAC_CB   = 4'd8;
   localparam logic [3:0] S_CAC_CR   = 4'd9;
   localparam logic [3:0] S_CAC_CB_0 = 4'd10;
   localparam logic [3:0] S_CAC_CR_0 = 4'd11;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} phase_t;

   phase_t     phase;
   logic       i16;
   logic [3:0] cbp_l;
   logic [1:0] cbp_c;
   logic [3:0] nxt_state;
   logic [3:0] nxt_idx;
   logic [3:0] idx_inc;
   logic [3:0] first_state;
   logic [3:0] ac_cb;
   logic [3:0] ac_cr;
   logic       luma;
   logic       last;

   function automatic logic [3:0] luma_type(input logic intra, input logic coded);
      return intra ? (coded ? S_I16AC : S_I16AC_0) : (coded ? S_LUMA : S_LUMA_0);
   endfunction

   assign idx_inc     = blk_idx + 4'd1;
   assign luma        = residual_state >= S_I16AC && residual_state <= S_LUMA_0;
   assign first_state = is_intra16x16 ? S_I16DC : luma_type(1'b0, cbp_luma[0]);
   // cbp_chroma of 2 or 3 both mean AC coefficients are coded
   assign ac_cb       = cbp_c[1] ? S_CAC_CB : S_CAC_CB_0;
   assign ac_cr       = cbp_c[1] ? S_CAC_CR : S_CAC_CR_0;

   // Successor of the current block; last flags that no block follows
   always_comb begin
      nxt_state = residual_state;
      nxt_idx   = 4'd0;
      last      = 1'b0;
      if (residual_state == S_I16DC)
         nxt_state = luma_type(i16, cbp_l[0]);
      else if (luma && blk_idx != 4'd15) begin
         nxt_state = luma_type(i16, cbp_l[idx_inc[3:2]]);
         nxt_idx   = idx_inc;
      end
      else if (luma) begin
         last      = !CHROMA_EN;
         nxt_state = cbp_c != 2'd0 ? S_CDC_CB : ac_cb;
      end
      else if (residual_state == S_CDC_CB)
         nxt_state = S_CDC_CR;
      else if (residual_state == S_CDC_CR)
         nxt_state = ac_cb;
      else if (blk_idx != 4'd3)
         nxt_idx = idx_inc;
      else if (residual_state == ac_cb)
         nxt_state = ac_cr;
      else
         last = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         phase          <= IDLE;
         residual_state <= S_IDLE;
         blk_idx        <= 4'd0;
         busy           <= 1'b0;
         i16            <= 1'b0;
         cbp_l          <= 4'd0;
         cbp_c          <= 2'd0;
      end
      else if (ena) begin
         case (phase)
            IDLE:
               if (mb_start) begin
                  i16            <= is_intra16x16;
                  cbp_l          <= cbp_luma;
                  cbp_c          <= cbp_chroma;
                  residual_state <= first_state;
                  blk_idx        <= 4'd0;
                  busy           <= 1'b1;
                  phase          <= ISSUE;
               end
            // a valid left high from the previous block is deliberately ignored here
            ISSUE:
               phase <= WAIT;
            WAIT:
               if (residual_valid) begin
                  if (last) begin
                     residual_state <= S_IDLE;
                     blk_idx        <= 4'd0;
                     phase          <= DONE;
                  end
                  else begin
                     residual_state <= nxt_state;
                     blk_idx        <= nxt_idx;
                     phase          <= ISSUE;
                  end
               end
            default: begin
               busy  <= 1'b0;
               phase <= IDLE;
            end
         endcase
      end
   end

   assign residual_start = phase == ISSUE && ena;
   assign done           = phase == DONE && ena;
endmodule
